// File: rtl/eth_measurer_sweep.sv
// eth_measurer_sweep
//   Drives a ping-pong coordinator through a sweep of payload sizes. For each
//   size it collects pings_per_size completions and records good and lost
//   counts and min/max/sum round-trip time. It then offers one result record
//   over a valid/ready handshake and moves to the next size.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start, abort             one-cycle control pulses
//   psize_min/max/step       sweep range and increment (sampled on start)
//   pings_per_size           completions per size (sampled on start)
//   meas_enable/psize_req    request to the coordinator
//   meas_trigger/done        ping-launched / ping-completed pulses from it
//   meas_ping/pong_time      per-ping times, valid with meas_done
//   res_valid/ready, res_*   per-size result record
//   busy, sweep_done         status; sweep_done pulses only on normal end
module eth_measurer_sweep (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] psize_min,
    input  logic [15:0] psize_max,
    input  logic [15:0] psize_step,
    input  logic [15:0] pings_per_size,
    output logic        meas_enable,
    output logic [15:0] meas_psize_req,
    input  logic        meas_trigger,
    input  logic        meas_done,
    input  logic [31:0] meas_ping_time,
    input  logic [31:0] meas_pong_time,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_psize,
    output logic [15:0] res_good,
    output logic [15:0] res_lost,
    output logic [31:0] res_min_rtt,
    output logic [31:0] res_max_rtt,
    output logic [47:0] res_sum_rtt,
    output logic        busy,
    output logic        sweep_done
);

    typedef enum logic [2:0] {IDLE, RUN, REPORT, NEXT, DRAIN} state_t;

    localparam logic [31:0] LOST_TIME = 32'hFFFF_FFFF;
    localparam logic [31:0] RTT_SAT   = 32'hFFFF_FFFE;

    state_t      state_q, state_d;
    logic [15:0] max_q, max_d;
    logic [15:0] step_q, step_d;
    logic [15:0] pings_q, pings_d;
    logic [15:0] cur_q, cur_d;
    logic [15:0] done_cnt_q, done_cnt_d;
    logic [15:0] good_q, good_d;
    logic [15:0] lost_q, lost_d;
    logic [31:0] min_q, min_d;
    logic [31:0] maxr_q, maxr_d;
    logic [47:0] sum_q, sum_d;
    logic        in_flight_q, in_flight_d;
    logic        sweep_done_q, sweep_done_d;
    logic        drain_cnt_q, drain_cnt_d;

    logic [32:0] rtt_wide;
    logic [31:0] rtt;
    logic        ping_lost;
    logic        last_done;
    logic [16:0] next_psize;
    logic        clr_acc;

    // Saturate to one below the lost marker so a good rtt never reads as lost.
    assign rtt_wide   = {1'b0, meas_ping_time} + {1'b0, meas_pong_time};
    assign rtt        = (rtt_wide > {1'b0, RTT_SAT}) ? RTT_SAT : rtt_wide[31:0];
    assign ping_lost  = (meas_ping_time == LOST_TIME) || (meas_pong_time == LOST_TIME);
    assign next_psize = {1'b0, cur_q} + {1'b0, step_q};

    // Combinational drop on the final completion so the coordinator cannot
    // launch one extra ping in the cycle before REPORT.
    assign last_done   = meas_done && (done_cnt_q == pings_q - 16'd1);
    assign meas_enable = (state_q == RUN) && !last_done;

    assign meas_psize_req = cur_q;
    assign res_valid      = (state_q == REPORT);
    assign res_psize      = cur_q;
    assign res_good       = good_q;
    assign res_lost       = lost_q;
    assign res_min_rtt    = min_q;
    assign res_max_rtt    = maxr_q;
    assign res_sum_rtt    = sum_q;
    assign busy           = (state_q != IDLE);
    assign sweep_done     = sweep_done_q;

    always_comb begin
        state_d      = state_q;
        max_d        = max_q;
        step_d       = step_q;
        pings_d      = pings_q;
        cur_d        = cur_q;
        done_cnt_d   = done_cnt_q;
        good_d       = good_q;
        lost_d       = lost_q;
        min_d        = min_q;
        maxr_d       = maxr_q;
        sum_d        = sum_q;
        sweep_done_d = 1'b0;
        drain_cnt_d  = drain_cnt_q;
        clr_acc      = 1'b0;

        // Trigger wins over done so a back-to-back launch stays tracked.
        if (meas_trigger)   in_flight_d = 1'b1;
        else if (meas_done) in_flight_d = 1'b0;
        else                in_flight_d = in_flight_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    max_d   = psize_max;
                    step_d  = psize_step;
                    pings_d = pings_per_size;
                    if (pings_per_size == 16'd0 || psize_min > psize_max) begin
                        sweep_done_d = 1'b1;
                    end else begin
                        cur_d   = psize_min;
                        clr_acc = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    drain_cnt_d = 1'b0;
                    state_d     = DRAIN;
                end else if (meas_done) begin
                    done_cnt_d = done_cnt_q + 16'd1;
                    if (ping_lost) begin
                        lost_d = lost_q + 16'd1;
                    end else begin
                        good_d = good_q + 16'd1;
                        sum_d  = sum_q + {16'd0, rtt};
                        if (rtt < min_q)  min_d  = rtt;
                        if (rtt > maxr_q) maxr_d = rtt;
                    end
                    if (({1'b0, done_cnt_q} + 17'd1) == {1'b0, pings_q})
                        state_d = REPORT;
                end
            end
            REPORT: begin
                if (abort)          state_d = IDLE;
                else if (res_ready) state_d = NEXT;
            end
            NEXT: begin
                if (step_q == 16'd0 || next_psize > {1'b0, max_q}) begin
                    sweep_done_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    cur_d   = next_psize[15:0];
                    clr_acc = 1'b1;
                    state_d = RUN;
                end
            end
            DRAIN: begin
                // First DRAIN cycle always passes, giving the minimum of two.
                drain_cnt_d = 1'b1;
                if (drain_cnt_q && !in_flight_q && !meas_trigger)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (clr_acc) begin
            done_cnt_d = 16'd0;
            good_d     = 16'd0;
            lost_d     = 16'd0;
            min_d      = LOST_TIME;
            maxr_d     = 32'd0;
            sum_d      = 48'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            max_q        <= 16'd0;
            step_q       <= 16'd0;
            pings_q      <= 16'd0;
            cur_q        <= 16'd0;
            done_cnt_q   <= 16'd0;
            good_q       <= 16'd0;
            lost_q       <= 16'd0;
            min_q        <= LOST_TIME;
            maxr_q       <= 32'd0;
            sum_q        <= 48'd0;
            in_flight_q  <= 1'b0;
            sweep_done_q <= 1'b0;
            drain_cnt_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            max_q        <= max_d;
            step_q       <= step_d;
            pings_q      <= pings_d;
            cur_q        <= cur_d;
            done_cnt_q   <= done_cnt_d;
            good_q       <= good_d;
            lost_q       <= lost_d;
            min_q        <= min_d;
            maxr_q       <= maxr_d;
            sum_q        <= sum_d;
            in_flight_q  <= in_flight_d;
            sweep_done_q <= sweep_done_d;
            drain_cnt_q  <= drain_cnt_d;
        end
    end

endmodule

// File: tb/tb_eth_measurer_sweep.sv
module tb_eth_measurer_sweep;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort;
    logic [15:0] psize_min, psize_max, psize_step, pings_per_size;
    logic        meas_enable;
    logic [15:0] meas_psize_req;
    logic        meas_trigger, meas_done;
    logic [31:0] meas_ping_time, meas_pong_time;
    logic        res_valid, res_ready;
    logic [15:0] res_psize, res_good, res_lost;
    logic [31:0] res_min_rtt, res_max_rtt;
    logic [47:0] res_sum_rtt;
    logic        busy, sweep_done;

    eth_measurer_sweep dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .psize_min(psize_min), .psize_max(psize_max), .psize_step(psize_step),
        .pings_per_size(pings_per_size),
        .meas_enable(meas_enable), .meas_psize_req(meas_psize_req),
        .meas_trigger(meas_trigger), .meas_done(meas_done),
        .meas_ping_time(meas_ping_time), .meas_pong_time(meas_pong_time),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_psize(res_psize), .res_good(res_good), .res_lost(res_lost),
        .res_min_rtt(res_min_rtt), .res_max_rtt(res_max_rtt), .res_sum_rtt(res_sum_rtt),
        .busy(busy), .sweep_done(sweep_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] psize, good, lost;
        logic [31:0] mn, mx;
        logic [47:0] sum;
    } res_t;

    res_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Coordinator pattern: ping = tc_ping + idx*tc_inc, pong = tc_pong,
    // except index tc_bad whose pong is the lost marker.
    logic [31:0] tc_ping, tc_inc, tc_pong;
    int          tc_bad, tc_lat, cfg_pings;
    int          ping_idx, trig_cnt, done_total, sd_cnt;
    bit          en_seen, rv_seen;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] pat_ping(input int i);
        return tc_ping + tc_inc * i;
    endfunction

    function automatic logic [31:0] pat_pong(input int i);
        return (i == tc_bad) ? 32'hFFFF_FFFF : tc_pong;
    endfunction

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    // Expected per-size records for one sweep.
    task automatic push_expected(input logic [15:0] mn, input logic [15:0] mx,
                                 input logic [15:0] st, input logic [15:0] np);
        logic [16:0] ps;
        logic [32:0] s;
        logic [31:0] r, pg, pn;
        res_t e;
        if (np == 0 || mn > mx) return;
        ps = {1'b0, mn};
        forever begin
            e.psize = ps[15:0]; e.good = 0; e.lost = 0;
            e.mn = 32'hFFFF_FFFF; e.mx = 0; e.sum = 0;
            for (int i = 0; i < int'(np); i++) begin
                pg = pat_ping(i);
                pn = pat_pong(i);
                if (pg == 32'hFFFF_FFFF || pn == 32'hFFFF_FFFF) begin
                    e.lost++;
                end else begin
                    s = {1'b0, pg} + {1'b0, pn};
                    r = (s >= 33'h0_FFFF_FFFF) ? 32'hFFFF_FFFE : s[31:0];
                    e.good++;
                    e.sum = e.sum + {16'd0, r};
                    if (r < e.mn) e.mn = r;
                    if (r > e.mx) e.mx = r;
                end
            end
            exp_q.push_back(e);
            ps = ps + {1'b0, st};
            if (st == 0 || ps > {1'b0, mx}) break;
        end
    endtask

    // Behavioural ping-pong coordinator.
    initial begin
        bit outst;
        int lc;
        outst = 0; lc = 0;
        meas_trigger = 0; meas_done = 0;
        meas_ping_time = 0; meas_pong_time = 0;
        forever begin
            @(negedge clk);
            #1;
            meas_trigger = 0;
            meas_done = 0;
            if (rst) begin
                outst = 0;
            end else if (outst) begin
                if (lc <= 1) begin
                    meas_done = 1;
                    meas_ping_time = pat_ping(cfg_pings == 0 ? 0 : ping_idx % cfg_pings);
                    meas_pong_time = pat_pong(cfg_pings == 0 ? 0 : ping_idx % cfg_pings);
                    ping_idx++;
                    done_total++;
                    outst = 0;
                end else begin
                    lc--;
                end
            end else if (meas_enable) begin
                meas_trigger = 1;
                outst = 1;
                lc = tc_lat;
                trig_cnt++;
            end
        end
    end

    // Result monitor / scoreboard pop, sampled just before the rising edge.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            #4;
            if (meas_enable) en_seen = 1;
            if (res_valid)   rv_seen = 1;
            if (sweep_done)  sd_cnt++;
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_psize", res_psize, e.psize);
                    chk("res_good", res_good, e.good);
                    chk("res_lost", res_lost, e.lost);
                    chk("res_min", res_min_rtt, e.mn);
                    chk("res_max", res_max_rtt, e.mx);
                    chk("res_sum", res_sum_rtt, e.sum);
                end
            end
        end
    end

    task automatic set_pat(input logic [31:0] p, input logic [31:0] inc,
                           input logic [31:0] q, input int bad);
        tc_ping = p; tc_inc = inc; tc_pong = q; tc_bad = bad;
    endtask

    task automatic begin_sweep(input logic [15:0] mn, input logic [15:0] mx,
                               input logic [15:0] st, input logic [15:0] np);
        sd_cnt = 0; trig_cnt = 0; ping_idx = 0; en_seen = 0; rv_seen = 0;
        cfg_pings = int'(np);
        push_expected(mn, mx, st, np);
        psize_min = mn; psize_max = mx; psize_step = st; pings_per_size = np;
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic run_sweep(input string tag, input logic [15:0] mn, input logic [15:0] mx,
                             input logic [15:0] st, input logic [15:0] np);
        bit ok;
        begin_sweep(mn, mx, st, np);
        ok = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (!busy && sd_cnt > 0) begin ok = 1; break; end
        end
        if (!ok) chk({tag, "_timeout"}, 0, 1);
        repeat (3) tick();
        chk({tag, "_sweep_done"}, sd_cnt, 1);
        chk({tag, "_results_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        bit ok, stable;
        int t0;
        rst = 1; start = 0; abort = 0; res_ready = 1;
        psize_min = 0; psize_max = 0; psize_step = 0; pings_per_size = 0;
        tc_lat = 3; cfg_pings = 0;
        ping_idx = 0; trig_cnt = 0; done_total = 0; sd_cnt = 0;
        set_pat(100, 0, 150, -1);
        repeat (3) tick();
        chk("rst_enable", meas_enable, 0);
        chk("rst_psize_req", meas_psize_req, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sweep_done", sweep_done, 0);
        chk("rst_min_rtt", res_min_rtt, 32'hFFFF_FFFF);
        chk("rst_max_rtt", res_max_rtt, 0);
        chk("rst_sum_rtt", res_sum_rtt, 0);
        chk("rst_good", res_good, 0);
        rst = 0;
        tick();

        // Three sizes, all good.
        set_pat(100, 0, 150, -1);
        run_sweep("basic", 64, 128, 32, 2);
        chk("basic_triggers", trig_cnt, 6);

        // One lost pong in the middle of three pings.
        set_pat(100, 20, 150, 1);
        run_sweep("onelost", 64, 64, 16, 3);
        chk("onelost_triggers", trig_cnt, 3);

        // Every ping lost.
        set_pat(32'hFFFF_FFFF, 0, 150, -1);
        run_sweep("alllost", 100, 100, 1, 4);

        // Saturating rtt with step 0: single size only.
        set_pat(32'hFFFF_0000, 0, 32'h0002_0000, -1);
        run_sweep("sat", 500, 900, 0, 2);

        // Zero pings and inverted range: sweep_done only.
        set_pat(100, 0, 150, -1);
        run_sweep("zero_pings", 64, 128, 32, 0);
        chk("zero_pings_enable", en_seen, 0);
        run_sweep("bad_range", 200, 100, 8, 2);
        chk("bad_range_enable", en_seen, 0);

        // Backpressure: hold res_ready low in REPORT.
        set_pat(100, 0, 150, -1);
        res_ready = 0;
        begin_sweep(200, 200, 4, 2);
        ok = 0;
        for (int c = 0; c < 200; c++) begin
            if (res_valid) begin ok = 1; break; end
            tick();
        end
        chk("hold_reach_report", ok, 1);
        t0 = trig_cnt;
        stable = 1;
        for (int c = 0; c < 10; c++) begin
            if (!(res_valid && res_psize == 200 && res_good == 2 && res_lost == 0 &&
                  res_min_rtt == 250 && res_max_rtt == 250 && res_sum_rtt == 500 &&
                  !meas_enable && busy))
                stable = 0;
            tick();
        end
        chk("hold_stable", stable, 1);
        chk("hold_no_trigger", trig_cnt - t0, 0);
        res_ready = 1;
        tick();
        chk("hold_advance", res_valid, 0);
        ok = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (!busy && sd_cnt > 0) begin ok = 1; break; end
        end
        chk("hold_finish", ok, 1);
        chk("hold_results_left", exp_q.size(), 0);
        exp_q.delete();

        // Abort one cycle after a trigger: drain until the matching done.
        tc_lat = 6;
        set_pat(100, 0, 150, -1);
        begin_sweep(64, 64, 1, 4);
        exp_q.delete();
        done_total = 0;
        ok = 0;
        for (int c = 0; c < 100; c++) begin
            if (trig_cnt > 0) begin ok = 1; break; end
            tick();
        end
        chk("abort_saw_trigger", ok, 1);
        tick();
        abort = 1;
        tick();
        abort = 0;
        tick();
        chk("abort_enable_low", meas_enable, 0);
        chk("abort_still_busy", busy, 1);
        ok = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (!busy) begin ok = 1; break; end
        end
        chk("abort_to_idle", ok, 1);
        chk("abort_done_seen", done_total, 1);
        repeat (5) tick();
        chk("abort_triggers", trig_cnt, 1);
        chk("abort_no_result", rv_seen, 0);
        chk("abort_no_sweep_done", sd_cnt, 0);

        // Reset in the middle of a sweep.
        tc_lat = 3;
        begin_sweep(300, 400, 50, 3);
        exp_q.delete();
        ok = 0;
        for (int c = 0; c < 100; c++) begin
            if (trig_cnt > 0) begin ok = 1; break; end
            tick();
        end
        chk("midrst_saw_trigger", ok, 1);
        rst = 1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_enable", meas_enable, 0);
        chk("midrst_psize_req", meas_psize_req, 0);
        tick();
        rst = 0;
        repeat (8) tick();
        chk("midrst_idle", busy, 0);
        chk("midrst_no_result", rv_seen, 0);
        chk("midrst_no_sweep_done", sd_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/eth_measurer_sweep.md
ETH_MEASURER_SWEEP -- requirements
Module: eth_measurer_sweep

Interface
REQ-001 Parameter: none; all widths fixed as listed.
REQ-002 clk  in  1  sole clock; all logic on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  one-cycle pulse, begins a sweep; ignored unless IDLE.
REQ-005 abort  in  1  one-cycle pulse, stops a running sweep.
REQ-006 psize_min, psize_max, psize_step  in  16 each  sweep range and increment; latched on accepted start.
REQ-007 pings_per_size  in  16  pings per size; latched on accepted start.
REQ-008 meas_enable  out  1  enable to the ping-pong coordinator.
REQ-009 meas_psize_req  out  16  payload size request to the coordinator.
REQ-010 meas_trigger  in  1  coordinator main TX trigger pulse (ping launched).
REQ-011 meas_done  in  1  coordinator done pulse; meas_ping_time, meas_pong_time (in, 32 each) valid with it.
REQ-012 res_valid  out 1 / res_ready  in 1  per-size result handshake.
REQ-013 res_psize 16, res_good 16, res_lost 16, res_min_rtt 32, res_max_rtt 32, res_sum_rtt 48  out  result fields.
REQ-014 busy  out  1  high in any state other than IDLE; sweep_done  out  1  one-cycle pulse at normal sweep end.

Function
REQ-015 States: IDLE, RUN, REPORT, NEXT, DRAIN.
- IDLE: on start, latch config; if pings_per_size==0 or psize_min>psize_max, pulse sweep_done next cycle and remain IDLE; else set cur_psize=psize_min, clear accumulators, go RUN.
REQ-016 meas_psize_req SHALL equal cur_psize and change only while meas_enable is low.
REQ-017 meas_enable = (state==RUN) AND NOT(meas_done AND done_cnt==pings_per_size-1), the second term combinational so no further ping launches after the last done.
REQ-018 In RUN, each meas_done increments done_cnt; a ping is lost if meas_ping_time or meas_pong_time equals 32'hFFFFFFFF (res_lost+1), else good (res_good+1).
REQ-019 Good ping: rtt = ping+pong computed in 33 bits, saturated to 32'hFFFFFFFE; min_rtt=min(min_rtt,rtt), max_rtt=max(max_rtt,rtt), sum_rtt+=rtt (48-bit, wraps modulo 2^48).
REQ-020 Accumulator init per size: min_rtt=32'hFFFFFFFF, max_rtt=0, sum_rtt=0, good=lost=done_cnt=0; if good stays 0 these values are reported unchanged.
REQ-021 When done_cnt reaches pings_per_size, go REPORT next cycle; res_valid high, all res_* stable until res_valid&&res_ready, then NEXT.
REQ-022 NEXT (one cycle): next=cur_psize+psize_step in 17 bits; if psize_step==0 or next>psize_max, pulse sweep_done and go IDLE; else cur_psize=next, clear accumulators, go RUN.
REQ-023 in_flight flag: set on meas_trigger, cleared on meas_done; same-cycle trigger and done leaves it set.
REQ-024 abort in RUN: meas_enable low from next cycle, go DRAIN; DRAIN lasts at least 2 cycles and exits to IDLE once in_flight==0 and meas_trigger==0; no result, no sweep_done; meas_done in DRAIN is not accumulated.
REQ-025 abort in REPORT: drop res_valid, go IDLE; abort in IDLE/NEXT/DRAIN ignored; start outside IDLE ignored.
REQ-026 abort and meas_done in the same RUN cycle: abort wins, done not accumulated.

Reset
REQ-027 While rst high: state=IDLE, meas_enable=0, meas_psize_req=0, res_valid=0, all res_* fields and accumulators 0 except min_rtt=32'hFFFFFFFF, in_flight=0, busy=0, sweep_done=0.
REQ-028 rst asserted mid-sweep returns to IDLE immediately with no result or sweep_done emitted.

Verification
REQ-029 min=64,max=128,step=32,pings=2, all pongs good (ping=100,pong=150) -> three results psize 64/96/128, good=2, lost=0, min=max=250, sum=500, then one sweep_done.
REQ-030 pings=3, second done has pong=FFFFFFFF -> good=2, lost=1, min/max/sum over the two good pings only; exactly 3 triggers observed.
REQ-031 All pings lost (ping=FFFFFFFF) -> good=0, lost=N, min=FFFFFFFF, max=0, sum=0.
REQ-032 res_ready held low 10 cycles in REPORT -> res_valid and fields stable, meas_enable low, no trigger; advance one cycle after ready.
REQ-033 abort one cycle after meas_trigger -> DRAIN until the matching meas_done, then IDLE, busy low, no result, no sweep_done.
REQ-034 ping=FFFF0000,pong=00020000 -> rtt saturates to FFFFFFFE; step=0 -> single size then sweep_done; pings=0 -> sweep_done only, meas_enable never high.
